// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer and its stall watchdog.
// State encoding, parameter defaults and the performance-counter width.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam int MAX_STALL_DEF  = 64;
    localparam int MD_MAX_LAT_DEF = 34;
    localparam int CNT_W          = 32;
    localparam int WD_W           = 16;

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// Stall watchdog: tracks consecutive front-end stall cycles and mul/div wait
// cycles, and raises a sticky timeout that only reset clears.
module pipe_stall_watchdog
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_STALL  = MAX_STALL_DEF,
    parameter int MD_MAX_LAT = MD_MAX_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic md_wait,
    output logic timeout
);

    localparam logic [WD_W-1:0] STALL_LIM = WD_W'(MAX_STALL);
    localparam logic [WD_W-1:0] MD_LIM    = WD_W'(MD_MAX_LAT);

    logic [WD_W-1:0] stall_cnt;
    logic [WD_W-1:0] md_cnt;
    logic [WD_W-1:0] stall_nxt;
    logic [WD_W-1:0] md_nxt;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stall_nxt = '0;
        md_nxt    = '0;
        if (stall) begin
            stall_nxt = (stall_cnt == STALL_LIM) ? stall_cnt : stall_cnt + WD_W'(1);
        end
        // md_cnt parks one above the limit so it cannot wrap back under it.
        if (md_wait) begin
            md_nxt = (md_cnt > MD_LIM) ? md_cnt : md_cnt + WD_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            md_cnt    <= '0;
            timeout   <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            md_cnt    <= md_nxt;
            timeout   <= timeout | (stall_nxt == STALL_LIM) | (md_nxt > MD_LIM);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: prioritises mul/div occupancy, hazard stalls and branch
// redirects into per-stage stall/flush controls. Perf counters: PIPE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_STALL  = MAX_STALL_DEF,
    parameter int MD_MAX_LAT = MD_MAX_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             HazStallD,
    input  logic             PCSrcD,
    input  logic             MdStartE,
    input  logic             MdDoneE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             StallTimeout,
    output logic [CNT_W-1:0] PerfLwCnt,
    output logic [CNT_W-1:0] PerfMdCnt,
    output logic [CNT_W-1:0] PerfFlushCnt
);

    state_t state;
    logic   md_busy;
    logic   haz_apply;

    // A start with done in the same cycle is a single-cycle op and never occupies the unit.
    assign md_busy   = !reset && ((state == RUN) ? (MdStartE && !MdDoneE) : !MdDoneE);
    assign haz_apply = !reset && !md_busy && HazStallD;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else if (md_busy) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (haz_apply) begin
            // The branch is re-resolved next cycle with correct operands, so no FlushD here.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (PCSrcD) begin
            FlushD = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (MdStartE && !MdDoneE) state <= MD_WAIT;
                MD_WAIT: if (MdDoneE) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    pipe_stall_watchdog #(
        .MAX_STALL  (MAX_STALL),
        .MD_MAX_LAT (MD_MAX_LAT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .stall   (StallF),
        .md_wait (state == MD_WAIT),
        .timeout (StallTimeout)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] lw_cnt;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            lw_cnt    <= '0;
            md_cnt    <= '0;
            flush_cnt <= '0;
        end else begin
            lw_cnt    <= lw_cnt + CNT_W'(haz_apply);
            md_cnt    <= md_cnt + CNT_W'(md_busy);
            flush_cnt <= flush_cnt + CNT_W'(FlushD);
        end
    end

    assign PerfLwCnt    = lw_cnt;
    assign PerfMdCnt    = md_cnt;
    assign PerfFlushCnt = flush_cnt;
`else
    assign PerfLwCnt    = '0;
    assign PerfMdCnt    = '0;
    assign PerfFlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int TB_MAX_STALL  = 4;
    localparam int TB_MD_MAX_LAT = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             HazStallD = 1'b0;
    logic             PCSrcD = 1'b0;
    logic             MdStartE = 1'b0;
    logic             MdDoneE = 1'b0;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM, StallTimeout;
    logic [CNT_W-1:0] PerfLwCnt, PerfMdCnt, PerfFlushCnt;

    pipeline_ctrl #(
        .MAX_STALL  (TB_MAX_STALL),
        .MD_MAX_LAT (TB_MD_MAX_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .HazStallD    (HazStallD),
        .PCSrcD       (PCSrcD),
        .MdStartE     (MdStartE),
        .MdDoneE      (MdDoneE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM),
        .StallTimeout (StallTimeout),
        .PerfLwCnt    (PerfLwCnt),
        .PerfMdCnt    (PerfMdCnt),
        .PerfFlushCnt (PerfFlushCnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: a mul/div is in flight, length of the current stall run, length of
    // the current wait, sticky timeout and the three event tallies.
    bit          m_in_flight = 1'b0;
    int          m_run = 0;
    int          m_wait = 0;
    bit          m_timeout = 1'b0;
    int unsigned m_lw = 0;
    int unsigned m_md = 0;
    int unsigned m_fl = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input bit r, input bit h, input bit p, input bit s, input bit d);
        bit       occ;
        bit       lw;
        bit [5:0] exp_v;  // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
        @(negedge clk);
        reset = r; HazStallD = h; PCSrcD = p; MdStartE = s; MdDoneE = d;
        #1;
        occ = !r && (m_in_flight ? !d : (s && !d));
        lw  = !r && !occ && h;
        if (r)        exp_v = 6'b000111;
        else if (occ) exp_v = 6'b111001;
        else if (h)   exp_v = 6'b110010;
        else if (p)   exp_v = 6'b000100;
        else          exp_v = 6'b000000;
        check("ctrl", 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM}), 32'(exp_v));
        check("timeout", 32'(StallTimeout), 32'(m_timeout));
`ifdef PIPE_CTRL_PERF_EN
        check("perf_lw", PerfLwCnt, m_lw);
        check("perf_md", PerfMdCnt, m_md);
        check("perf_flush", PerfFlushCnt, m_fl);
`else
        check("perf_lw", PerfLwCnt, 32'd0);
        check("perf_md", PerfMdCnt, 32'd0);
        check("perf_flush", PerfFlushCnt, 32'd0);
`endif
        @(posedge clk);
        if (r) begin
            m_in_flight = 1'b0; m_run = 0; m_wait = 0; m_timeout = 1'b0;
            m_lw = 0; m_md = 0; m_fl = 0;
        end else begin
            m_run  = exp_v[5] ? ((m_run < TB_MAX_STALL) ? m_run + 1 : m_run) : 0;
            m_wait = m_in_flight ? m_wait + 1 : 0;
            if (m_run == TB_MAX_STALL || m_wait > TB_MD_MAX_LAT) m_timeout = 1'b1;
            m_lw += 32'(lw);
            m_md += 32'(occ);
            m_fl += 32'(exp_v[2]);
            m_in_flight = m_in_flight ? !d : (s && !d);
        end
    endtask

    initial begin
        // Establish a known register state before any comparison.
        @(posedge clk);

        // Reset held two cycles, then idle.
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Hazard with a concurrent branch, then the branch alone.
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Four-cycle mul/div with a hazard pulse that must be ignored.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Single-cycle op and a stray done.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Watchdog: five hazard cycles against a limit of four, sticky until reset.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        #1;
        check("timeout_sticky", 32'(StallTimeout), 32'd1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Mul/div overrunning its maximum latency, then reset mid-wait.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(31) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(5) == 0, $urandom_range(3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
